// File: rtl/triad_pkg.sv
// Shared types and sizing helpers for the triad decoder.
// TRIAD_DECODER_BX_EN widens each hit by a BX timestamp.
package triad_pkg;

   localparam int TRIAD_LEN = 3;

   typedef enum logic [1:0] {
      IDLE,
      BIT1,
      BIT2
   } lane_state_t;

`ifdef TRIAD_DECODER_BX_EN
   localparam bit BX_EN = 1'b1;
`else
   localparam bit BX_EN = 1'b0;
`endif

   function automatic int addr_width(input int nstrip);
      return $clog2(nstrip) + 2;
   endfunction

   function automatic int hit_width(input int addr_w, input int bx_w);
      return BX_EN ? addr_w + bx_w : addr_w;
   endfunction

   // Frame length in samples; the lane FSM below walks exactly this many states.
   function automatic int frame_len();
      return TRIAD_LEN;
   endfunction

endpackage

// File: rtl/triad_hit_fifo.sv
// First-word-fall-through hit FIFO: the head entry is presented whenever count is non-zero,
// and the output reads 0 while empty. Accepts a write when full only alongside a pop.
module triad_hit_fifo #(
   parameter int  WIDTH = 5,
   parameter int  DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             valid,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_wr;
   logic             do_rd;

   assign valid = (count_reg != '0);
   assign full  = (count_reg == CNT_W'(DEPTH));
   assign do_rd = rd_en && valid;
   assign do_wr = wr_en && (!full || do_rd);

   always_ff @(posedge clock) begin
      if (do_wr) mem[wr_ptr_reg] <= wr_data;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_wr) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_rd) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({do_wr, do_rd})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // When full with a simultaneous pop, the write lands in the slot just vacated by the head.
   assign rd_data = valid ? mem[rd_ptr_reg] : '0;
   assign count   = count_reg;

endmodule

// File: rtl/triad_decoder.sv
// Deserializes per-lane triad frames into half-strip hits and queues them round-robin
// into a FWFT FIFO. Define TRIAD_DECODER_BX_EN to prefix each hit with a BX timestamp.
module triad_decoder
   import triad_pkg::*;
#(
   parameter int  NSTRIP     = 8,
   parameter int  FIFO_DEPTH = 16,
   parameter int  BX_W       = 12,
   localparam int ADDR_W     = addr_width(NSTRIP),
   localparam int HIT_W      = hit_width(ADDR_W, BX_W),
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [NSTRIP-1:0] triad_in,
   input  logic              bx0,
   output logic              hit_valid,
   input  logic              hit_ready,
   output logic [HIT_W-1:0]  hit_data,
   output logic [CNT_W-1:0]  fifo_count,
   output logic [15:0]       drop_count,
   input  logic              drop_clear
);

   localparam int LANE_W = ADDR_W - 2;

   logic [NSTRIP-1:0] hold_valid;
   logic [NSTRIP-1:0] grant;
   logic [NSTRIP-1:0] drop;
   logic [HIT_W-1:0]  hold_data [NSTRIP];
   logic [LANE_W-1:0] ptr_reg;
   logic [LANE_W-1:0] grant_idx;
   logic [LANE_W-1:0] cand_idx;
   logic              grant_found;
   logic              grant_ok;
   logic              fifo_full;
   logic              pop;
   int                arb_idx;
   logic [15:0]       drop_count_reg;
   logic [LANE_W:0]   drop_n;
   logic [16:0]       drop_sum;

`ifdef TRIAD_DECODER_BX_EN
   logic [BX_W-1:0] bx_cnt_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)  bx_cnt_reg <= '0;
      else if (bx0)  bx_cnt_reg <= '0;
      else           bx_cnt_reg <= bx_cnt_reg + BX_W'(1);
   end
`else
   logic unused_bx0;
   assign unused_bx0 = bx0;
`endif

   for (genvar gi = 0; gi < NSTRIP; gi++) begin : g_lane
      lane_state_t      state_reg;
      logic             pair_reg;
      logic             hold_valid_reg;
      logic [HIT_W-1:0] hold_data_reg;
      logic [HIT_W-1:0] frame;
      logic             done;

`ifdef TRIAD_DECODER_BX_EN
      logic [BX_W-1:0] ts_reg;

      // Timestamp is the counter value seen with the start bit, before any bx0 clear.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n)                               ts_reg <= '0;
         else if (state_reg == IDLE && triad_in[gi]) ts_reg <= bx_cnt_reg;
      end
      assign frame = {ts_reg, LANE_W'(gi), pair_reg, triad_in[gi]};
`else
      assign frame = {LANE_W'(gi), pair_reg, triad_in[gi]};
`endif

      assign done     = (state_reg == BIT2);
      assign drop[gi] = done && hold_valid_reg && !grant[gi];

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            state_reg      <= IDLE;
            pair_reg       <= 1'b0;
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
         end else begin
            case (state_reg)
               IDLE:    if (triad_in[gi]) state_reg <= BIT1;
               BIT1: begin
                  pair_reg  <= triad_in[gi];
                  state_reg <= BIT2;
               end
               default: state_reg <= IDLE;
            endcase
            // A lane granted this cycle frees its holding register in time for a new frame.
            if (done && (!hold_valid_reg || grant[gi])) begin
               hold_valid_reg <= 1'b1;
               hold_data_reg  <= frame;
            end else if (grant[gi]) begin
               hold_valid_reg <= 1'b0;
            end
         end
      end

      assign hold_valid[gi] = hold_valid_reg;
      assign hold_data[gi]  = hold_data_reg;
   end

   assign pop      = hit_valid && hit_ready;
   assign grant_ok = !fifo_full || pop;

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand_idx    = '0;
      arb_idx     = 0;
      grant       = '0;
      for (int k = 0; k < NSTRIP; k++) begin
         arb_idx = int'(ptr_reg) + k;
         if (arb_idx >= NSTRIP) arb_idx = arb_idx - NSTRIP;
         cand_idx = LANE_W'(arb_idx);
         if (!grant_found && hold_valid[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
      if (grant_found && grant_ok) grant[grant_idx] = 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_reg <= '0;
      end else if (|grant) begin
         ptr_reg <= (grant_idx == LANE_W'(NSTRIP - 1)) ? '0 : grant_idx + LANE_W'(1);
      end
   end

   // Several lanes can drop in one cycle; each dropped frame counts.
   always_comb begin
      drop_n = '0;
      for (int k = 0; k < NSTRIP; k++) drop_n = drop_n + (LANE_W + 1)'(drop[k]);
      drop_sum = 17'(drop_count_reg) + 17'(drop_n);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)         drop_count_reg <= '0;
      else if (drop_clear)  drop_count_reg <= '0;
      else if (drop_sum[16]) drop_count_reg <= 16'hFFFF;
      else                  drop_count_reg <= drop_sum[15:0];
   end

   assign drop_count = drop_count_reg;

   triad_hit_fifo #(
      .WIDTH (HIT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .wr_en   (|grant),
      .wr_data (hold_data[grant_idx]),
      .rd_en   (hit_ready),
      .rd_data (hit_data),
      .valid   (hit_valid),
      .full    (fifo_full),
      .count   (fifo_count)
   );

endmodule

// File: tb/tb_triad_decoder.sv
// Self-checking bench for triad_decoder: vector table, directed corner cases and
// randomized traffic against a queue-based reference model. Honors TRIAD_DECODER_BX_EN.
`timescale 1ns/1ps
module tb_triad_decoder;

   localparam int NSTRIP     = 8;
   localparam int FIFO_DEPTH = 16;
   localparam int BX_W       = 12;
   localparam int ADDR_W     = $clog2(NSTRIP) + 2;
`ifdef TRIAD_DECODER_BX_EN
   localparam bit BX_EN = 1'b1;
   localparam int HIT_W = ADDR_W + BX_W;
`else
   localparam bit BX_EN = 1'b0;
   localparam int HIT_W = ADDR_W;
`endif
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic              clock = 1'b0;
   logic              reset_n;
   logic [NSTRIP-1:0] triad_in;
   logic              bx0;
   logic              hit_valid;
   logic              hit_ready;
   logic [HIT_W-1:0]  hit_data;
   logic [CNT_W-1:0]  fifo_count;
   logic [15:0]       drop_count;
   logic              drop_clear;

   always #5 clock = ~clock;

   triad_decoder #(
      .NSTRIP     (NSTRIP),
      .FIFO_DEPTH (FIFO_DEPTH),
      .BX_W       (BX_W)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .triad_in   (triad_in),
      .bx0        (bx0),
      .hit_valid  (hit_valid),
      .hit_ready  (hit_ready),
      .hit_data   (hit_data),
      .fifo_count (fifo_count),
      .drop_count (drop_count),
      .drop_clear (drop_clear)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: frame progress per lane, pending hit per lane, FIFO as a queue.
   int m_phase [NSTRIP];
   int m_ts    [NSTRIP];
   int m_pair  [NSTRIP];
   bit m_hv    [NSTRIP];
   int m_hd    [NSTRIP];
   int m_q [$];
   int m_ptr;
   int m_drop;
   int m_bx;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int addr_of(input int lane, input int pair, input int side);
      return lane * 4 + pair * 2 + side;
   endfunction

   task automatic model_reset();
      for (int l = 0; l < NSTRIP; l++) begin
         m_phase[l] = 0; m_ts[l] = 0; m_pair[l] = 0; m_hv[l] = 1'b0; m_hd[l] = 0;
      end
      m_q.delete();
      m_ptr  = 0;
      m_drop = 0;
      m_bx   = 0;
   endtask

   task automatic model_step();
      bit pop;
      bit can;
      int g;
      int nd;
      int val;
      int popped;
      pop = (m_q.size() > 0) && hit_ready;
      can = (m_q.size() < FIFO_DEPTH) || pop;
      g = -1;
      if (can)
         for (int k = 0; k < NSTRIP; k++)
            if (g < 0 && m_hv[(m_ptr + k) % NSTRIP]) g = (m_ptr + k) % NSTRIP;
      if (pop) begin
         popped = m_q.pop_front();
         $display("[TB] hit accepted: data=0x%0h lane=%0d", popped, (popped >> 2) % NSTRIP);
      end
      if (g >= 0) begin
         m_q.push_back(m_hd[g]);
         m_hv[g] = 1'b0;
         m_ptr   = (g + 1) % NSTRIP;
      end
      nd = 0;
      for (int l = 0; l < NSTRIP; l++) begin
         case (m_phase[l])
            0: if (triad_in[l]) begin m_phase[l] = 1; m_ts[l] = m_bx; end
            1: begin m_pair[l] = int'(triad_in[l]); m_phase[l] = 2; end
            default: begin
               val = (m_ts[l] << ADDR_W) + addr_of(l, m_pair[l], int'(triad_in[l]));
               if (m_hv[l]) nd++;
               else begin m_hv[l] = 1'b1; m_hd[l] = val; end
               m_phase[l] = 0;
            end
         endcase
      end
      if (drop_clear) m_drop = 0;
      else            m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
      if (BX_EN) m_bx = bx0 ? 0 : (m_bx + 1) % (1 << BX_W);
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_valid"}, int'(hit_valid), int'(m_q.size() > 0));
      chk({tag, "_data"},  int'(hit_data),  (m_q.size() > 0) ? m_q[0] : 0);
      chk({tag, "_count"}, int'(fifo_count), m_q.size());
      chk({tag, "_drop"},  int'(drop_count), m_drop);
   endtask

   task automatic tick(input string tag);
      @(posedge clock);
      model_step();
      #1;
      check_model(tag);
   endtask

   task automatic send_frames(input logic [NSTRIP-1:0] lanes,
                              input logic [NSTRIP-1:0] pairs,
                              input logic [NSTRIP-1:0] sides);
      triad_in = lanes;         tick("s0");
      triad_in = pairs & lanes; tick("s1");
      triad_in = sides & lanes; tick("s2");
      triad_in = '0;
   endtask

   typedef struct {
      int lane;
      bit pair;
      bit side;
      int exp_addr;
   } vec_t;

   vec_t              vecs [6];
   int                exp_a [3];
   int                exp_b [3];
   int                exp_q [$];
   int                got_q [$];
   logic [NSTRIP-1:0] m;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; triad_in = '0; bx0 = 1'b0; hit_ready = 1'b0; drop_clear = 1'b0;
      model_reset();
      #3;
      chk("reset_valid", int'(hit_valid), 0);
      chk("reset_data",  int'(hit_data), 0);
      chk("reset_count", int'(fifo_count), 0);
      chk("reset_drop",  int'(drop_count), 0);
      #5 reset_n = 1'b1;

      // Single frames: latency and address decode.
      vecs[0] = '{5, 1'b1, 1'b0, 'h16};
      vecs[1] = '{0, 1'b0, 1'b0, 'h00};
      vecs[2] = '{2, 1'b0, 1'b1, 'h09};
      vecs[3] = '{3, 1'b1, 1'b1, 'h0F};
      vecs[4] = '{6, 1'b0, 1'b1, 'h19};
      vecs[5] = '{7, 1'b1, 1'b1, 'h1F};
      hit_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         m = '0;
         m[vecs[i].lane] = 1'b1;
         send_frames(m, vecs[i].pair ? m : '0, vecs[i].side ? m : '0);
         chk("lat_e2_valid", int'(hit_valid), 0);
         tick("vec");
         chk("lat_e3_valid", int'(hit_valid), 1);
         chk("vec_addr", int'(hit_data[ADDR_W-1:0]), vecs[i].exp_addr);
         $display("[TB] vector lane=%0d addr=0x%0h", vecs[i].lane, hit_data[ADDR_W-1:0]);
         tick("vec");
         chk("vec_count0", int'(fifo_count), 0);
      end

      // Simultaneous lanes 0,3,7 with pointer at 0, then with pointer at 4.
      exp_a[0] = 'h01; exp_a[1] = 'h0D; exp_a[2] = 'h1D;
      exp_b[0] = 'h1D; exp_b[1] = 'h01; exp_b[2] = 'h0D;
      send_frames(8'h89, 8'h00, 8'h89);
      for (int j = 0; j < 3; j++) begin
         tick("simul");
         chk("simul_order_ptr0", int'(hit_data[ADDR_W-1:0]), exp_a[j]);
      end
      tick("simul");
      send_frames(8'h08, 8'h00, 8'h08);
      tick("simul"); tick("simul");
      send_frames(8'h89, 8'h00, 8'h89);
      for (int j = 0; j < 3; j++) begin
         tick("simul");
         chk("simul_order_ptr4", int'(hit_data[ADDR_W-1:0]), exp_b[j]);
      end
      tick("simul");

      // Back-pressure: 20 frames into a 16-deep FIFO, then 2 frames on occupied lanes.
      hit_ready = 1'b0;
      send_frames(8'hFF, 8'hAA, 8'h0F); repeat (10) tick("bp");
      send_frames(8'hFF, 8'hAA, 8'h0F); repeat (10) tick("bp");
      send_frames(8'h0F, 8'hAA, 8'h0F); repeat (2) tick("bp");
      send_frames(8'h03, 8'hAA, 8'h0F); repeat (2) tick("bp");
      chk("bp_count_full", int'(fifo_count), 16);
      chk("bp_drops", int'(drop_count), 2);
      chk("bp_valid", int'(hit_valid), 1);
      exp_q.delete();
      for (int w = 0; w < 2; w++)
         for (int k = 0; k < NSTRIP; k++)
            exp_q.push_back(addr_of((4 + k) % NSTRIP, ('hAA >> ((4 + k) % NSTRIP)) & 1,
                                    ('h0F >> ((4 + k) % NSTRIP)) & 1));
      for (int l = 0; l < 4; l++) exp_q.push_back(addr_of(l, ('hAA >> l) & 1, 1));
      hit_ready = 1'b1;
      got_q.delete();
      for (int c = 0; c < 40 && got_q.size() < 20; c++) begin
         if (hit_valid) got_q.push_back(int'(hit_data[ADDR_W-1:0]));
         tick("drain");
         if (c == 0) chk("full_pop_count", int'(fifo_count), 16);
      end
      chk("drain_total", got_q.size(), 20);
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk("drain_order", got_q[i], exp_q[i]);
      drop_clear = 1'b1; tick("clr"); drop_clear = 1'b0;
      chk("drop_clear", int'(drop_count), 0);

      // Reset mid-frame with one hit already queued.
      hit_ready = 1'b0;
      send_frames(8'h20, 8'h20, 8'h00);
      tick("prerst");
      chk("prerst_count", int'(fifo_count), 1);
      triad_in = 8'h04; tick("rst_s0");
      triad_in = 8'h04; tick("rst_s1");
      triad_in = '0;
      reset_n = 1'b0;
      #1;
      chk("midrst_valid", int'(hit_valid), 0);
      chk("midrst_data",  int'(hit_data), 0);
      chk("midrst_count", int'(fifo_count), 0);
      chk("midrst_drop",  int'(drop_count), 0);
      model_reset();
      #1 reset_n = 1'b1;
      repeat (4) tick("postrst");
      chk("postrst_no_hit", int'(hit_valid), 0);
      hit_ready = 1'b1;
      send_frames(8'h04, 8'h00, 8'h04);
      tick("postrst");
      chk("postrst_clean", int'(hit_data[ADDR_W-1:0]), 'h09);
      tick("postrst");

      // Randomized traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         for (int l = 0; l < NSTRIP; l++) triad_in[l] = ($urandom_range(0, 3) == 0);
         hit_ready  = ($urandom_range(0, 9) < 7);
         drop_clear = ($urandom_range(0, 99) == 0);
         bx0        = ($urandom_range(0, 49) == 0);
         tick("rand");
      end
      triad_in = '0; hit_ready = 1'b1; drop_clear = 1'b0; bx0 = 1'b0;
      repeat (6) tick("idle");

`ifdef TRIAD_DECODER_BX_EN
      // Timestamp wrap, then bx0 clear before a start and coincident with a start.
      for (int c = 0; c < 5000 && m_bx != 4095; c++) tick("bx_wait");
      chk("bx_wait", m_bx, 4095);
      triad_in = 8'h02; tick("bx");
      triad_in = 8'h02; tick("bx");
      triad_in = 8'h00; tick("bx");
      triad_in = 8'h02; tick("bx");
      chk("bx_wrap_ts",   int'(hit_data[HIT_W-1:ADDR_W]), 4095);
      chk("bx_wrap_addr", int'(hit_data[ADDR_W-1:0]), 'h06);
      triad_in = 8'h00; tick("bx");
      triad_in = 8'h02; tick("bx");
      triad_in = 8'h00; tick("bx");
      chk("bx_after_wrap", int'(hit_data[HIT_W-1:ADDR_W]), 2);
      chk("bx_after_addr", int'(hit_data[ADDR_W-1:0]), 'h05);
      tick("bx");
      bx0 = 1'b1; tick("bx"); bx0 = 1'b0;
      send_frames(8'h02, 8'h00, 8'h00);
      tick("bx");
      chk("bx0_cleared", int'(hit_data[HIT_W-1:ADDR_W]), 0);
      tick("bx");
      bx0 = 1'b1; tick("bx"); bx0 = 1'b0;
      tick("bx"); tick("bx");
      triad_in = 8'h02; bx0 = 1'b1; tick("bx");
      bx0 = 1'b0; triad_in = 8'h00; tick("bx"); tick("bx");
      tick("bx");
      chk("bx0_same_edge", int'(hit_data[HIT_W-1:ADDR_W]), 2);
      tick("bx");
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/triad_decoder.md
# triad_decoder

Consumes the 3-bit serialized triad frames produced by a bank of distrip peak-finder stages. Each lane is deserialized into a half-strip hit. A configurable timestamp can be attached to each hit. Completed hits are arbitrated round-robin into a shared FIFO and offered downstream on a valid/ready interface. The block sits directly after the distrip array and before the cluster/readout logic.

## Interface
- NSTRIP, 8: number of distrip serial lanes; ADDR_W = $clog2(NSTRIP)+2
- FIFO_DEPTH, 16: hit FIFO entries, power of two, ≥2
- BX_W, 12: timestamp counter width (used only with TRIAD_DECODER_BX_EN)

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- triad_in  in  NSTRIP  serial frame input, one bit per lane
- bx0  in  1  synchronous timestamp-counter clear
- hit_valid  out  1  FIFO head valid
- hit_ready  in  1  downstream accepts head
- hit_data  out  HIT_W  {bx (opt), lane, pair, side}; HIT_W = ADDR_W (+BX_W with macro)
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- drop_count  out  16  saturating count of dropped frames
- drop_clear  in  1  synchronous clear of drop_count

## Operation
- Frame per lane: start bit 1 at sample S0, then pair bit at S1 (1 = second distrip of pair), then side bit at S2 (1 = strip left). Upstream guarantees ≥3 cycles from one start bit to the next. A 0 in IDLE is ignored.
- Per-lane FSM: IDLE → (triad_in=1) → BIT1 → BIT2 → IDLE, unconditionally. triad_in is ignored as a start bit while in BIT1 or BIT2.
- BIT1 captures pair. At BIT2 the lane holding register loads {lane, pair, side}, plus the timestamp latched at S0, and sets hold_valid.
- Arbiter: round-robin over hold_valid lanes. One grant per cycle.
  - A grant is allowed when FIFO not full, or when full and a pop occurs in the same cycle.
  - The pointer moves to granted lane + 1, mod NSTRIP.
  - A grant clears hold_valid and writes the FIFO.
- Overflow: if a lane completes a frame while its hold_valid is set and not granted that cycle, the new frame is dropped and drop_count increments.
  - If the lane is granted in that cycle, the new frame loads normally.
  - drop_count saturates at 16'hFFFF.
  - If drop_clear and an increment occur in the same cycle, drop_count becomes 0; clear wins.
- Half-strip address = {lane, pair, side}. hit_data with macro: {bx[BX_W-1:0], lane, pair, side}.
- The BX counter is free running and wraps from 2^BX_W−1 to 0. bx0 sets it to 0 at the next edge.
- FIFO is first-word-fall-through. Pop occurs on hit_valid && hit_ready. hit_data is stable while hit_valid && !hit_ready.

## Timing
- Reset values: all FSMs IDLE, hold_valid 0, pointer 0, hit_valid 0, hit_data 0, fifo_count 0, drop_count 0, BX counter 0.
- Reset asserted mid-frame discards partial frames and all FIFO contents.
- Latency: start bit sampled at edge E0 → hold_valid after E2 → FIFO write at E3 → hit_valid high after E3. This is 3 cycles with an empty FIFO and no contention.
- Contention adds 1 cycle per lane granted ahead in round-robin order.
- fifo_count updates on the edge of each write or pop. On simultaneous write and pop it is unchanged.
- Timestamp is the counter value at E0. With bx0 at E0, the frame gets the pre-clear value.

## Configuration
- TRIAD_DECODER_BX_EN defined: BX counter present; hit_data width ADDR_W+BX_W with timestamp in the MSBs.
- TRIAD_DECODER_BX_EN undefined: no counter; bx0 is ignored; hit_data width ADDR_W.

## Structure
- Shared package triad_pkg:
  - lane FSM state enum (IDLE, BIT1, BIT2)
  - hit struct/width helper functions
  - frame length constant TRIAD_LEN = 3
- One sub-module: triad_hit_fifo, a synchronous first-word-fall-through FIFO parameterized by width and depth, with count output. Per-lane FSMs are a generate loop in the top.

## Test plan
- Single frame: lane 5 receives 1,1,0 with FIFO empty, hit_ready=1 → hit_valid high 3 cycles after the start-bit edge; address {5,1,0}=0x16; fifo_count returns to 0.
- Simultaneous: lanes 0, 3, 7 start on the same edge → hits emerge in lane order 0, 3, 7 on consecutive cycles. A repeat with the pointer at 4 gives order 7, 0, 3.
- Back-pressure: hit_ready=0, 20 frames spread across lanes with FIFO_DEPTH=16 → fifo_count=16, held hits stay in their holding registers. Further frames on occupied lanes increment drop_count. After hit_ready=1, all non-dropped hits drain in order.
- Full with pop: FIFO full, hit_ready=1, one pending hold → write and pop in the same cycle; fifo_count stays at 16.
- Timestamp (macro on, BX_W=12): counter at 4095 at the start edge → hit bx = 4095. The next frame carries bx 0–2 after the wrap. bx0 pulse → the following frame's bx counts from 0.
- Reset mid-frame: reset_n low after bit 1 of a frame on lane 2 → no hit produced, all outputs 0. A clean frame afterwards decodes correctly.
